// File: rtl/eh2_dec_gpr_wbq.sv
// rtl/eh2_dec_gpr_wbq.sv - GPR writeback queue for long-latency producers (optional EH2_WBQ_BYPASS_EN)
module eh2_dec_gpr_wbq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic             alloc_tid,
    input  logic [4:0]       alloc_addr,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic [31:0]      res_data,
    input  logic             flush_valid,
    input  logic             flush_tid,
    input  logic             port_free,
    output logic             wen,
    output logic             wtid,
    output logic [4:0]       waddr,
    output logic [31:0]      wd,
    output logic [31:0]      busy0,
    output logic [31:0]      busy1,
    output logic             empty
);

    localparam logic [2:0] ST_FREE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_KILL  = 3'd3;
    localparam logic [2:0] ST_KDONE = 3'd4;
    localparam logic [TAG_W:0] LP_FULL = (TAG_W+1)'(DEPTH);

    logic [2:0]       r_state [DEPTH];
    logic             r_tid   [DEPTH];
    logic [4:0]       r_addr  [DEPTH];
    logic [31:0]      r_data  [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic             w_alloc;
    logic             w_retire;
    logic             w_bypass;
    logic             w_busy_hit;
    logic [2:0]       w_head_state;
    logic             w_head_tid;
    logic [4:0]       w_head_addr;
    logic             w_head_zero;
    logic [DEPTH-1:0] w_flush_hit;
    logic [DEPTH-1:0] w_res_hit;

    // Busy scoreboard: a destination is pending while its live, unflushed entry awaits retire
    always_comb begin
        busy0 = '0;
        busy1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((r_state[i] == ST_WAIT || r_state[i] == ST_DONE) && r_addr[i] != 5'd0) begin
                if (r_tid[i]) busy1[r_addr[i]] = 1'b1;
                else          busy0[r_addr[i]] = 1'b1;
            end
        end
    end

    assign w_busy_hit  = alloc_tid ? busy1[alloc_addr] : busy0[alloc_addr];
    assign alloc_ready = (r_count != LP_FULL) && !w_busy_hit;
    assign alloc_tag   = r_tail;
    assign w_alloc     = alloc_valid && alloc_ready;
    assign empty       = (r_count == '0);

    assign w_head_state = r_state[r_head];
    assign w_head_tid   = r_tid[r_head];
    assign w_head_addr  = r_addr[r_head];
    assign w_head_zero  = (w_head_addr == 5'd0);

`ifdef EH2_WBQ_BYPASS_EN
    assign w_bypass = (w_head_state == ST_WAIT) && res_valid && (res_tag == r_head) && port_free &&
                      !(flush_valid && flush_tid == w_head_tid);
`else
    assign w_bypass = 1'b0;
`endif

    // Per-entry flush and result hits, evaluated on pre-edge state
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_flush_hit[i] = flush_valid && (r_state[i] != ST_FREE) && (r_tid[i] == flush_tid);
            w_res_hit[i]   = res_valid && (res_tag == TAG_W'(i));
        end
    end

    // Drain: only the head entry may write or retire; address 0 and flushed entries retire silently
    always_comb begin
        w_retire = 1'b0;
        wen      = 1'b0;
        wd       = r_data[r_head];
        case (w_head_state)
            ST_DONE: begin
                w_retire = port_free || w_head_zero;
                wen      = port_free && !w_head_zero;
            end
            ST_KDONE: w_retire = 1'b1;
            ST_WAIT: begin
                if (w_bypass) begin
                    w_retire = 1'b1;
                    wen      = !w_head_zero;
                    wd       = res_data;
                end
            end
            default: ;
        endcase
        wtid  = wen ? w_head_tid  : 1'b0;
        waddr = wen ? w_head_addr : 5'd0;
        if (!wen) wd = 32'd0;
    end

    // Entry state machines and queue pointers; retire beats alloc, flush beats a same-cycle result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_tid[i]   <= 1'b0;
                r_addr[i]  <= 5'd0;
                r_data[i]  <= 32'd0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_retire && TAG_W'(i) == r_head) begin
                    r_state[i] <= ST_FREE;
                end else if (w_alloc && TAG_W'(i) == r_tail) begin
                    r_state[i] <= ST_WAIT;
                    r_tid[i]   <= alloc_tid;
                    r_addr[i]  <= alloc_addr;
                end else begin
                    case (r_state[i])
                        ST_WAIT: begin
                            if (w_flush_hit[i]) begin
                                r_state[i] <= w_res_hit[i] ? ST_KDONE : ST_KILL;
                            end else if (w_res_hit[i]) begin
                                r_state[i] <= ST_DONE;
                                r_data[i]  <= res_data;
                            end
                        end
                        ST_DONE: if (w_flush_hit[i]) r_state[i] <= ST_KDONE;
                        ST_KILL: if (w_res_hit[i])   r_state[i] <= ST_KDONE;
                        default: ;
                    endcase
                end
            end
            if (w_retire) r_head <= r_head + TAG_W'(1);
            if (w_alloc)  r_tail <= r_tail + TAG_W'(1);
            r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
        end
    end

endmodule

// File: doc/eh2_dec_gpr_wbq.md
Name: eh2_dec_gpr_wbq

Overview:
- Writeback queue for long-latency GPR producers (divider, non-blocking load return); the writer end of the GPR file's write port 3.
- Allocates a tagged entry when a long-latency instruction issues, keeps a per-thread busy scoreboard, and accepts results out of order.
- Drains completed entries in order onto one GPR write port when that port is free.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, at least 2).
- TAG_W, 2, entry tag width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- alloc_valid  in  1  allocation request
- alloc_tid  in  1  thread of destination
- alloc_addr  in  5  destination GPR
- alloc_ready  out  1  entry available and alloc_addr not busy for alloc_tid
- alloc_tag  out  TAG_W  tag assigned (tail pointer)
- res_valid  in  1  result return
- res_tag  in  TAG_W  entry the result belongs to
- res_data  in  32  result value
- flush_valid  in  1  kill all uncommitted entries of flush_tid
- flush_tid  in  1  thread being flushed
- port_free  in  1  GPR write port 3 unused by the pipe this cycle
- wen  out  1  GPR write enable
- wtid  out  1  write thread
- waddr  out  5  write address
- wd  out  32  write data
- busy0  out  32  pending-destination bitmap, thread 0 (bit 0 always 0)
- busy1  out  32  pending-destination bitmap, thread 1
- empty  out  1  no valid entries

Behaviour:
- Entry states: FREE, WAIT (allocated, no result), DONE (result held), KILL (flushed, result still outstanding), KDONE (flushed, result arrived).
- Reset: all entries FREE; head, tail and count are 0; busy0 and busy1 are 0; wen is 0; empty is 1; alloc_ready is 1.
- Allocation:
  - The entry is written when alloc_valid & alloc_ready: tail entry goes FREE to WAIT, tail increments modulo DEPTH, count increments.
  - The busy bit for (alloc_tid, alloc_addr) is set at the next edge.
  - alloc_ready = (count != DEPTH) & ~busy[alloc_tid][alloc_addr]. It is computed from pre-edge state, so a retire does not free a slot in the same cycle.
  - alloc_addr 0 is legal: the entry is allocated, no busy bit is set, and the entry retires without a write.
- Result:
  - res_valid moves the res_tag entry WAIT to DONE (data captured) or KILL to KDONE.
  - res_valid to a FREE, DONE or KDONE entry is a protocol error; it is ignored with no state change.
- Flush:
  - Every non-FREE entry whose tid equals flush_tid moves WAIT to KILL, or DONE to KDONE.
  - Its busy bit clears at the next edge.
  - If flush and res_valid hit the same entry in the same cycle, the flush wins and the final state is KDONE.
- Drain: only the head entry is considered.
  - DONE & port_free: wen=1 with the entry's tid, addr and data. The entry retires (goes FREE, head increments, count decrements) and its busy bit clears at that edge.
  - DONE with addr 0: wen=0 and it retires regardless of port_free.
  - KDONE: retires without a write, regardless of port_free.
  - WAIT or KILL: blocks the queue, and younger DONE entries wait behind it.
  - wen, wtid, waddr and wd are combinational from head state and port_free. waddr and wd are 0 when wen=0.
  - At most one retire per cycle.
- Simultaneous alloc and retire: count is unchanged, pointers both advance.
- Full (count=DEPTH): alloc_ready=0, and result and drain operate normally.
- Wrap-around: pointers wrap modulo DEPTH, and tags reused after wrap are valid.
- Reset mid-operation: all state clears asynchronously. In-flight results arriving after reset are ignored because their entries are FREE.
- Latency:
  - Result to wen is at least 1 cycle: a result at edge N gives wen earliest in cycle N+1.
  - Busy set is visible the cycle after alloc.

Optional Feature:
- Macro EH2_WBQ_BYPASS_EN.
- Defined: when res_valid targets the head entry in WAIT, and port_free=1, and there is no flush of that tid this cycle, the result is written in the same cycle (wen=1, wd=res_data) and the entry retires directly WAIT to FREE. Result-to-write latency is 0.
- Undefined: the result is always captured into DONE first; latency is 1 cycle minimum.

Test Plan:
- Basic: alloc tid0/x5, result 0xDEADBEEF two cycles later with port_free=1 -> busy0[5]=1 from the cycle after alloc; wen=1, waddr=5, wd=0xDEADBEEF one cycle after the result; busy0[5]=0 afterward; empty=1.
- Out-of-order: alloc tags 0(x1), 1(x2); result tag1=0x22 then tag0=0x11 -> writes are x1=0x11, then x2=0x22 on consecutive cycles; no write while tag0 is WAIT.
- Full and port stall: four allocs, fifth with alloc_ready=0; all results returned with port_free=0 -> no wen; raising port_free gives 4 writes on 4 consecutive cycles, and alloc_ready returns 1 the cycle after the first retire.
- Flush: tid1 entries x3 (WAIT) and x4 (DONE) plus tid0 x3 (WAIT); flush_tid=1 -> busy1 clears next cycle, busy0[3] stays set; late result for the killed x3 produces no write; only tid0 x3 is written.
- Collision and duplicates: flush and result on the same entry in the same cycle -> KDONE, no write. Alloc tid0/x7 while tid0/x7 is busy -> alloc_ready=0. Alloc tid1/x7 is accepted.
- Bypass (EH2_WBQ_BYPASS_EN): head WAIT, result 0x5A5A with port_free=1 -> wen=1, wd=0x5A5A in the same cycle. Without the macro -> wen the next cycle.
